life_step_scheduler: RTL

Sequences the Game of Life engine: decides when one generation step or one seed load is issued to the grid datapath. Supports run, pause, single-step and reseed controls, plus a frame-rate divider. All commands are aligned to the start of vertical blanking, so the displayed grid never changes mid-frame. Sits between user-control synchronisers / VGA timing and the life engine, all on clk_40mhz.

---
 rtl/life_pkg.sv | 19 +
 rtl/life_frame_divider.sv | 51 +++++
 rtl/life_step_scheduler.sv | 127 ++++++++++++
 3 files changed

// File: rtl/life_pkg.sv
// Shared types and default widths for the Game of Life control path.
package life_pkg;

  localparam int SPEED_W_DEF = 4;
  localparam int GEN_W_DEF   = 16;

  typedef enum logic [1:0] {
    S_PAUSE,
    S_RUN_WAIT,
    S_ISSUE,
    S_WAIT
  } state_t;

  typedef enum logic {
    CMD_STEP,
    CMD_SEED
  } cmd_t;

endpackage

// File: rtl/life_frame_divider.sv
// Detects the start of vertical blanking and divides frames by 2^speed,
// producing a registered one-cycle tick and a matching step_due flag.
module life_frame_divider
  import life_pkg::*;
#(
  parameter int SPEED_W = SPEED_W_DEF
) (
  input  logic               clk_40mhz,
  input  logic               reset,
  input  logic               vblank,
  input  logic [SPEED_W-1:0] speed,
  input  logic               running,
  output logic               tick,
  output logic               step_due
);

  // Wide enough to hold 2^speed - 1 for the largest speed value.
  localparam int CNT_W = 1 << SPEED_W;

  logic             vblank_q;
  logic             rise;
  logic [CNT_W-1:0] frame_cnt;
  logic [CNT_W-1:0] limit;

  assign rise  = vblank & ~vblank_q;
  assign limit = (CNT_W'(1) << speed) - CNT_W'(1);

  always_ff @(posedge clk_40mhz or negedge reset) begin
    if (!reset) begin
      vblank_q  <= 1'b0;
      tick      <= 1'b0;
      step_due  <= 1'b0;
      frame_cnt <= '0;
    end else begin
      vblank_q <= vblank;
      tick     <= rise;
      step_due <= 1'b0;
      if (!running) begin
        frame_cnt <= '0;
      end else if (rise) begin
        if (frame_cnt >= limit) begin
          frame_cnt <= '0;
          step_due  <= 1'b1;
        end else begin
          frame_cnt <= frame_cnt + CNT_W'(1);
        end
      end
    end
  end

endmodule

// File: rtl/life_step_scheduler.sv
// Issues step/seed commands to the life engine, one per frame at most,
// aligned to vblank so the visible grid never changes mid-frame.
module life_step_scheduler
  import life_pkg::*;
#(
  parameter int SPEED_W      = SPEED_W_DEF,
  parameter int GEN_W        = GEN_W_DEF,
  parameter int DONE_TIMEOUT = 1024
) (
  input  logic               clk_40mhz,
  input  logic               reset,
  input  logic               run_toggle,
  input  logic               step_req,
  input  logic               seed_req,
  input  logic               vblank,
  input  logic [SPEED_W-1:0] speed,
  input  logic               engine_done,
  output logic               step_pulse,
  output logic               seed_pulse,
  output logic               running,
  output logic               busy,
  output logic [GEN_W-1:0]   gen_count,
  output logic               timeout_err
);

  localparam int TMO_W = $clog2(DONE_TIMEOUT + 1);

  state_t            state, state_nxt;
  cmd_t              cmd_q, cmd_nxt;
  state_t            idle_state;
  logic              tick, step_due;
  logic              seed_pend, step_pend;
  logic [TMO_W-1:0]  tmo_cnt;
  logic              done_ok, timed_out, consume;

  life_frame_divider #(.SPEED_W(SPEED_W)) u_divider (
    .clk_40mhz (clk_40mhz),
    .reset     (reset),
    .vblank    (vblank),
    .speed     (speed),
    .running   (running),
    .tick      (tick),
    .step_due  (step_due)
  );

  assign idle_state = running ? S_RUN_WAIT : S_PAUSE;
  assign done_ok    = (state == S_WAIT) && engine_done;
  assign timed_out  = (state == S_WAIT) && !engine_done &&
                      (tmo_cnt == TMO_W'(DONE_TIMEOUT - 1));
  assign consume    = done_ok || timed_out;

  always_ff @(posedge clk_40mhz or negedge reset) begin
    if (!reset) begin
      state <= S_PAUSE;
      cmd_q <= CMD_STEP;
    end else begin
      state <= state_nxt;
      cmd_q <= cmd_nxt;
    end
  end

  // Seed always wins; otherwise RUN uses the divider, PAUSE uses the pending step.
  always_comb begin
    state_nxt = state;
    cmd_nxt   = cmd_q;
    case (state)
      S_PAUSE, S_RUN_WAIT: begin
        state_nxt = idle_state;
        if (tick) begin
          if (seed_pend) begin
            state_nxt = S_ISSUE;
            cmd_nxt   = CMD_SEED;
          end else if (running ? step_due : step_pend) begin
            state_nxt = S_ISSUE;
            cmd_nxt   = CMD_STEP;
          end
        end
      end
      S_ISSUE: state_nxt = S_WAIT;
      S_WAIT:  if (consume) state_nxt = idle_state;
      default: state_nxt = S_PAUSE;
    endcase
  end

  always_comb begin
    step_pulse = 1'b0;
    seed_pulse = 1'b0;
    busy       = 1'b0;
    if (state == S_ISSUE) begin
      step_pulse = (cmd_q == CMD_STEP);
      seed_pulse = (cmd_q == CMD_SEED);
    end
    if (state == S_ISSUE || state == S_WAIT) busy = 1'b1;
  end

  // A new request in the same cycle as completion must not be lost, so set beats clear.
  always_ff @(posedge clk_40mhz or negedge reset) begin
    if (!reset) begin
      running     <= 1'b0;
      seed_pend   <= 1'b0;
      step_pend   <= 1'b0;
      tmo_cnt     <= '0;
      gen_count   <= '0;
      timeout_err <= 1'b0;
    end else begin
      running <= running ^ run_toggle;
      tmo_cnt <= (state == S_WAIT) ? tmo_cnt + TMO_W'(1) : '0;

      if (seed_req)
        seed_pend <= 1'b1;
      else if (consume && cmd_q == CMD_SEED)
        seed_pend <= 1'b0;

      if (step_req && !running)
        step_pend <= 1'b1;
      else if (consume && cmd_q == CMD_STEP)
        step_pend <= 1'b0;

      if (done_ok)
        gen_count <= (cmd_q == CMD_SEED) ? '0 : gen_count + GEN_W'(1);

      if (timed_out)
        timeout_err <= 1'b1;
    end
  end

endmodule
